// File: rtl/bla_line_drawer.sv
// rtl/bla_line_drawer.sv - Bresenham line rasteriser emitting one pixel per accepted handshake
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   draw_en    line request; endpoints are sampled only while idle
//   x0, y0     line start point (unsigned 8-bit)
//   x1, y1     line end point (unsigned 8-bit)
//   pix_ready  downstream accepts the presented pixel this cycle
//   pix_x      current pixel x coordinate
//   pix_y      current pixel y coordinate
//   pix_valid  pix_x/pix_y hold a pixel to be written
//   busy       high whenever a line is being set up, drawn or finished
//   draw_done  one-cycle pulse after the final pixel has been accepted
module bla_line_drawer (
  input  logic       clk,
  input  logic       rst,
  input  logic       draw_en,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic       pix_ready,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       pix_valid,
  output logic       busy,
  output logic       draw_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Endpoints captured when a request is accepted; the live inputs are
  // never looked at again until the block returns to IDLE.
  logic [7:0] end_x0;
  logic [7:0] end_y0;
  logic [7:0] end_x1;
  logic [7:0] end_y1;

  // Bresenham working set. dy is stored already negated so the error
  // update is a pure add in both axes.
  logic signed [9:0] dx;
  logic signed [9:0] dy;
  logic signed [9:0] err;
  logic              step_x_neg;
  logic              step_y_neg;
  logic [7:0]        cur_x;
  logic [7:0]        cur_y;

  logic signed [9:0]  diff_x;
  logic signed [9:0]  diff_y;
  logic signed [9:0]  abs_x;
  logic signed [9:0]  abs_y;
  logic signed [10:0] e2;
  logic signed [10:0] dx_ext;
  logic signed [10:0] dy_ext;
  logic               step_x;
  logic               step_y;
  logic               at_end;
  logic               consume;
  logic signed [9:0]  err_add_x;
  logic signed [9:0]  err_add_y;

  // Differences are formed with two guard bits so that 0-255 and 255-0
  // both fit as signed values before taking the magnitude.
  always_comb begin
    diff_x    = $signed({2'b00, end_x1}) - $signed({2'b00, end_x0});
    diff_y    = $signed({2'b00, end_y1}) - $signed({2'b00, end_y0});
    abs_x     = diff_x[9] ? -diff_x : diff_x;
    abs_y     = diff_y[9] ? -diff_y : diff_y;
    e2        = {err, 1'b0};
    dx_ext    = {dx[9], dx};
    dy_ext    = {dy[9], dy};
    step_x    = (e2 >= dy_ext);
    step_y    = (e2 <= dx_ext);
    at_end    = (cur_x == end_x1) && (cur_y == end_y1);
    consume   = (state == PLOT) && pix_ready;
    err_add_x = step_x ? dy : 10'sd0;
    err_add_y = step_y ? dx : 10'sd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (draw_en) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = PLOT;
      end
      PLOT: begin
        if (consume && at_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      end_x0     <= 8'd0;
      end_y0     <= 8'd0;
      end_x1     <= 8'd0;
      end_y1     <= 8'd0;
      dx         <= 10'sd0;
      dy         <= 10'sd0;
      err        <= 10'sd0;
      step_x_neg <= 1'b0;
      step_y_neg <= 1'b0;
      cur_x      <= 8'd0;
      cur_y      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (draw_en) begin
            end_x0 <= x0;
            end_y0 <= y0;
            end_x1 <= x1;
            end_y1 <= y1;
          end
        end
        LOAD: begin
          dx         <= abs_x;
          dy         <= -abs_y;
          err        <= abs_x - abs_y;
          step_x_neg <= !(end_x0 < end_x1);
          step_y_neg <= !(end_y0 < end_y1);
          cur_x      <= end_x0;
          cur_y      <= end_y0;
        end
        PLOT: begin
          // Both axis tests use the error from before this step, so a
          // diagonal move updates err with dx and dy together.
          if (consume && !at_end) begin
            err <= err + err_add_x + err_add_y;
            if (step_x) begin
              cur_x <= step_x_neg ? cur_x - 8'd1 : cur_x + 8'd1;
            end
            if (step_y) begin
              cur_y <= step_y_neg ? cur_y - 8'd1 : cur_y + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign pix_valid = (state == PLOT);
  assign busy      = (state != IDLE);
  assign draw_done = (state == DONE);

endmodule

// File: doc/bla_line_drawer.md
BLA_LINE_DRAWER -- requirements
Module: bla_line_drawer

Interface
REQ-001: The module SHALL use one clock; reset is synchronous and active-high.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous active-high reset.
REQ-004: draw_en  input  1  request from line controller; endpoints valid while high.
REQ-005: x0, y0  input  8 each  line start point (unsigned).
REQ-006: x1, y1  input  8 each  line end point (unsigned).
REQ-007: pix_ready  input  1  downstream frame-buffer writer accepts pixel this cycle.
REQ-008: pix_x, pix_y  output  8 each  current pixel coordinate.
REQ-009: pix_valid  output  1  pix_x/pix_y hold a valid pixel.
REQ-010: busy  output  1  high in every state except IDLE.
REQ-011: draw_done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-012: The FSM SHALL have states IDLE, LOAD, PLOT and DONE.
REQ-013: In IDLE with draw_en=1, the block SHALL latch x0,y0,x1,y1 and go to LOAD; in IDLE with draw_en=0, it SHALL stay in IDLE.
REQ-014: LOAD SHALL take exactly one cycle to compute:
- dx=|x1-x0|, dy=-|y1-y0|
- sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
- err=dx+dy
- cur=(x0,y0)
It SHALL then enter PLOT.
REQ-015: In PLOT, pix_valid SHALL be 1 and pix_x/pix_y SHALL equal cur.
REQ-016: A pixel SHALL be consumed only on a cycle with pix_valid=1 and pix_ready=1; while pix_ready=0, pix_x/pix_y/pix_valid SHALL hold.
REQ-017: On consumption with cur==(x1,y1), the block SHALL go to DONE.
REQ-018: On any other consumption, with e2=2*err:
- if e2>=dy: err+=dy and x+=sx
- if e2<=dx: err+=dx and y+=sy
- both updates apply in the same cycle when both conditions hold.
REQ-019: err SHALL be 10-bit signed and e2 11-bit signed; no overflow for any 8-bit endpoints.
REQ-020: DONE SHALL last one cycle with draw_done=1, pix_valid=0, then go to IDLE.
REQ-021: The number of pixels emitted SHALL be max(|x1-x0|,|y1-y0|)+1, covering all eight octants.
REQ-022: Emitted pixels SHALL start at (x0,y0) and end at (x1,y1).
REQ-023: Degenerate line (x0,y0)==(x1,y1): exactly one pixel SHALL be emitted, then DONE.
REQ-024: draw_en SHALL be ignored outside IDLE; endpoint changes during a line SHALL have no effect.
REQ-025: If draw_en is still high on return to IDLE, a new line SHALL start (IDLE->LOAD next edge).
REQ-026: Minimum latency SHALL be: draw_en sampled at edge N -> LOAD at N+1 -> first pix_valid visible after edge N+2.
REQ-027: With pix_ready held at 1, one pixel SHALL be consumed per cycle.

Reset
REQ-028: While rst=1 at a clock edge, state SHALL become IDLE and pix_x=0, pix_y=0, pix_valid=0, busy=0, draw_done=0, with all internal registers zero.
REQ-029: Reset mid-line SHALL abandon the line with no draw_done pulse.
REQ-030: After reset the block SHALL accept draw_en on the first cycle after rst falls.

Verification
REQ-031: Horizontal line (0,0)->(5,0), pix_ready=1 -> pixels x=0..5 with y=0 on 6 consecutive cycles, then one draw_done pulse.
REQ-032: Steep negative line (3,7)->(1,0) -> exactly (3,7),(3,6),(2,5),(2,4),(2,3),(2,2),(1,1),(1,0), then draw_done.
REQ-033: Single point (9,9)->(9,9) -> one pixel (9,9), then draw_done.
REQ-034: Diagonal (0,0)->(3,3) with pix_ready toggling 1,0,1,0 -> pixels (0,0)..(3,3); each pixel holds while pix_ready=0; 4 pixels total.
REQ-035: Reset mid-line: start (0,0)->(255,0), assert rst after 10 pixels -> pix_valid=0, busy=0 next cycle; no draw_done.
REQ-036: Back-to-back: draw_en held high with (0,0)->(1,1) -> draw_done pulse, then IDLE one cycle, then LOAD; second line of 2 pixels follows.
